fetch_ctrl: RTL and testbench

FETCH_CTRL -- requirements
Module: fetch_ctrl

---
 rtl/fetch_ctrl.sv | 152 +++++++++++++++
 tb/tb_fetch_ctrl.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: instruction-fetch controller for a 5-stage pipeline.
// Issues single outstanding fetch requests to instruction memory, absorbs
// memory wait states, redirects the PC on taken branches/jumps, and buffers
// a returned instruction while a load-use hazard stalls Decode.
//
// Ports:
//   clk, reset              clock, synchronous active-high reset
//   PCSrcE, PCTargetE       taken redirect from Execute and its target
//   Rs1D, Rs2D              Decode source registers
//   RdE, ResultSrcE0        Execute destination register, Execute is a load
//   ImemReady, ImemRdata    instruction memory response valid / word
//   ImemReq                 fetch request (address is PCF, held by StallF)
//   StallF, StallD          PC / IF-ID register stalls
//   FlushD, FlushE          IF-ID / ID-EX register flushes
//   PCRedirF, PCTargetF     PC load enable and value
//   InstrF                  word presented to the IF-ID register
//   WaitCount               saturating count of memory wait cycles
module fetch_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic        PCSrcE,
    input  logic [31:0] PCTargetE,
    input  logic [4:0]  Rs1D,
    input  logic [4:0]  Rs2D,
    input  logic [4:0]  RdE,
    input  logic        ResultSrcE0,
    input  logic        ImemReady,
    input  logic [31:0] ImemRdata,
    output logic        ImemReq,
    output logic        StallF,
    output logic        StallD,
    output logic        FlushD,
    output logic        FlushE,
    output logic        PCRedirF,
    output logic [31:0] PCTargetF,
    output logic [31:0] InstrF,
    output logic [15:0] WaitCount
);

    typedef enum logic [1:0] {
        ST_RST,
        ST_FETCH,
        ST_HOLD,
        ST_DRAIN
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] tgt_q, tgt_d;
    logic [31:0] buf_q, buf_d;
    logic [15:0] wait_count_q, wait_count_d;
    logic        load_use;

    assign WaitCount = wait_count_q;

    always_comb begin
        load_use  = ResultSrcE0 && (RdE != 5'd0) && ((Rs1D == RdE) || (Rs2D == RdE));

        state_d   = state_q;
        tgt_d     = tgt_q;
        buf_d     = buf_q;
        ImemReq   = 1'b0;
        StallF    = 1'b1;
        StallD    = 1'b0;
        FlushD    = 1'b0;
        FlushE    = 1'b0;
        PCRedirF  = 1'b0;
        PCTargetF = PCTargetE;
        InstrF    = ImemRdata;

        case (state_q)
            ST_RST: begin
                FlushD  = 1'b1;
                FlushE  = 1'b1;
                state_d = ST_FETCH;
            end
            ST_FETCH: begin
                ImemReq = 1'b1;
                if (PCSrcE) begin
                    FlushD = 1'b1;
                    FlushE = 1'b1;
                    if (ImemReady) begin
                        PCRedirF = 1'b1;
                        StallF   = 1'b0;
                    end else begin
                        // Request still in flight: remember the target and
                        // let the stale response drain before redirecting.
                        tgt_d   = PCTargetE;
                        state_d = ST_DRAIN;
                    end
                end else if (load_use) begin
                    StallD = 1'b1;
                    FlushE = 1'b1;
                    if (ImemReady) begin
                        buf_d   = ImemRdata;
                        state_d = ST_HOLD;
                    end
                end else if (ImemReady) begin
                    StallF = 1'b0;
                end else begin
                    FlushD = 1'b1;
                end
            end
            ST_HOLD: begin
                InstrF = buf_q;
                if (PCSrcE) begin
                    PCRedirF = 1'b1;
                    StallF   = 1'b0;
                    FlushD   = 1'b1;
                    FlushE   = 1'b1;
                    state_d  = ST_FETCH;
                end else if (load_use) begin
                    StallD = 1'b1;
                    FlushE = 1'b1;
                end else begin
                    StallF  = 1'b0;
                    state_d = ST_FETCH;
                end
            end
            ST_DRAIN: begin
                ImemReq = 1'b1;
                FlushD  = 1'b1;
                if (ImemReady) begin
                    PCRedirF  = 1'b1;
                    PCTargetF = tgt_q;
                    StallF    = 1'b0;
                    state_d   = ST_FETCH;
                end
            end
            default: state_d = ST_RST;
        endcase

        wait_count_d = wait_count_q;
        if (ImemReq && !ImemReady && (wait_count_q != '1)) begin
            wait_count_d = wait_count_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_RST;
            tgt_q        <= '0;
            buf_q        <= '0;
            wait_count_q <= '0;
        end else begin
            state_q      <= state_d;
            tgt_q        <= tgt_d;
            buf_q        <= buf_d;
            wait_count_q <= wait_count_d;
        end
    end

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: directed self-checking bench for fetch_ctrl.
// Control outputs are compared as a packed vector
// {ImemReq, StallF, StallD, FlushD, FlushE, PCRedirF}.
module tb_fetch_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        PCSrcE;
    logic [31:0] PCTargetE;
    logic [4:0]  Rs1D, Rs2D, RdE;
    logic        ResultSrcE0;
    logic        ImemReady;
    logic [31:0] ImemRdata;
    logic        ImemReq, StallF, StallD, FlushD, FlushE, PCRedirF;
    logic [31:0] PCTargetF, InstrF;
    logic [15:0] WaitCount;

    int n_checks = 0;
    int n_fails  = 0;

    fetch_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .PCSrcE     (PCSrcE),
        .PCTargetE  (PCTargetE),
        .Rs1D       (Rs1D),
        .Rs2D       (Rs2D),
        .RdE        (RdE),
        .ResultSrcE0(ResultSrcE0),
        .ImemReady  (ImemReady),
        .ImemRdata  (ImemRdata),
        .ImemReq    (ImemReq),
        .StallF     (StallF),
        .StallD     (StallD),
        .FlushD     (FlushD),
        .FlushE     (FlushE),
        .PCRedirF   (PCRedirF),
        .PCTargetF  (PCTargetF),
        .InstrF     (InstrF),
        .WaitCount  (WaitCount)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_ctl(input string tag, input logic [5:0] exp);
        #1;
        check(tag, {26'd0, ImemReq, StallF, StallD, FlushD, FlushE, PCRedirF}, {26'd0, exp});
    endtask

    task automatic set_lw(input logic ld, input logic [4:0] rd, input logic [4:0] r1, input logic [4:0] r2);
        ResultSrcE0 = ld;
        RdE         = rd;
        Rs1D        = r1;
        Rs2D        = r2;
    endtask

    initial begin
        reset = 1'b1; PCSrcE = 1'b0; PCTargetE = '0; ImemReady = 1'b0; ImemRdata = '0;
        set_lw(1'b0, 5'd0, 5'd0, 5'd0);

        // Reset state
        tick(); tick();
        chk_ctl("rst_ctl", 6'b010110);
        check("rst_wc", {16'd0, WaitCount}, 32'd0);

        // First cycle after reset: response ignored
        reset = 1'b0; ImemReady = 1'b1; ImemRdata = 32'h1111_1111;
        chk_ctl("post_rst_ctl", 6'b010110);
        tick();

        // Zero-wait stream
        for (int i = 0; i < 4; i++) begin
            ImemReady = 1'b1;
            ImemRdata = 32'h0010_0013 + 32'(i) * 32'h100;
            chk_ctl("zw_ctl", 6'b100000);
            check("zw_instr", InstrF, 32'h0010_0013 + 32'(i) * 32'h100);
            check("zw_wc", {16'd0, WaitCount}, 32'd0);
            tick();
        end

        // Three wait states then ready
        for (int i = 0; i < 3; i++) begin
            ImemReady = 1'b0;
            chk_ctl("wait_ctl", 6'b110100);
            tick();
        end
        ImemReady = 1'b1;
        chk_ctl("wait_done_ctl", 6'b100000);
        check("wait_wc", {16'd0, WaitCount}, 32'd3);
        tick();

        // Redirect mid-wait -> DRAIN
        ImemReady = 1'b0; PCSrcE = 1'b1; PCTargetE = 32'h0000_0040;
        chk_ctl("redir_wait_ctl", 6'b110110);
        tick();
        PCSrcE = 1'b0; PCTargetE = 32'h0000_0123; set_lw(1'b1, 5'd5, 5'd5, 5'd0);
        chk_ctl("drain_ctl", 6'b110100);
        tick();
        ImemReady = 1'b1; ImemRdata = 32'hDEAD_BEEF;
        chk_ctl("drain_rdy_ctl", 6'b100101);
        check("drain_tgt", PCTargetF, 32'h0000_0040);
        check("drain_wc", {16'd0, WaitCount}, 32'd5);
        tick();

        // Load-use with response -> HOLD, buffered word released next cycle
        ImemRdata = 32'h00A0_0093;
        chk_ctl("lu_ctl", 6'b111010);
        tick();
        set_lw(1'b0, 5'd0, 5'd0, 5'd0); ImemRdata = 32'hFFFF_FFFF;
        chk_ctl("hold_rel_ctl", 6'b000000);
        check("hold_instr", InstrF, 32'h00A0_0093);
        tick();

        // Load-use via Rs2D, HOLD stays while hazard persists, then redirect
        set_lw(1'b1, 5'd7, 5'd1, 5'd7); ImemRdata = 32'h1234_5678;
        chk_ctl("lu2_ctl", 6'b111010);
        tick();
        ImemRdata = 32'h0;
        chk_ctl("hold_lw_ctl", 6'b011010);
        check("hold_lw_instr", InstrF, 32'h1234_5678);
        tick();
        PCSrcE = 1'b1; PCTargetE = 32'h0000_0080;
        chk_ctl("hold_redir_ctl", 6'b000111);
        check("hold_redir_tgt", PCTargetF, 32'h0000_0080);
        tick();

        // Redirect with ready in FETCH, beats a concurrent load-use
        PCTargetE = 32'h0000_0100; ImemReady = 1'b1;
        chk_ctl("fetch_redir_ctl", 6'b100111);
        check("fetch_redir_tgt", PCTargetF, 32'h0000_0100);
        tick();

        // Load on x0 is not a hazard
        PCSrcE = 1'b0; set_lw(1'b1, 5'd0, 5'd0, 5'd0); ImemRdata = 32'hCAFE_F00D;
        chk_ctl("x0_ctl", 6'b100000);
        check("x0_instr", InstrF, 32'hCAFE_F00D);
        tick();

        // Load-use without response stays in FETCH
        set_lw(1'b1, 5'd3, 5'd3, 5'd0); ImemReady = 1'b0;
        chk_ctl("lu_wait_ctl", 6'b111010);
        tick();
        set_lw(1'b0, 5'd0, 5'd0, 5'd0); ImemReady = 1'b1; ImemRdata = 32'h0000_0013;
        chk_ctl("lu_wait_done_ctl", 6'b100000);
        check("lu_wait_wc", {16'd0, WaitCount}, 32'd6);
        tick();

        // Reset asserted mid-DRAIN
        PCSrcE = 1'b1; PCTargetE = 32'h0000_0200; ImemReady = 1'b0;
        chk_ctl("redir2_ctl", 6'b110110);
        tick();
        PCSrcE = 1'b0;
        chk_ctl("drain2_ctl", 6'b110100);
        reset = 1'b1;
        tick();
        chk_ctl("rst_drain_ctl", 6'b010110);
        check("rst_drain_wc", {16'd0, WaitCount}, 32'd0);
        reset = 1'b0;
        tick();

        // WaitCount saturation
        for (int i = 0; i < 65540; i++) begin
            tick();
        end
        chk_ctl("sat_ctl", 6'b110100);
        check("sat_wc", {16'd0, WaitCount}, 32'h0000_FFFF);
        tick();
        #1;
        check("sat_hold_wc", {16'd0, WaitCount}, 32'h0000_FFFF);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
        $finish;
    end

endmodule
